// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and backing-memory port of mem_arbiter,
// plus the pipeline stall and error outputs. The arbiter uses the slave view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata,
           stall_if, stall_mem, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata,
           stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and load/store accesses onto one memory
// port with alternating tie-break, pipeline stall outputs and an acknowledge watchdog.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              grant_i_s;
  logic              grant_d_s;
  logic              ack_s;
  logic              abort_s;
  logic [DATA_W-1:0] rdata_s;

  logic              last_d_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              m_req_r;
  logic              m_we_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wdata_r;
  logic              i_ready_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic              d_ready_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              err_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode with grant, completion and watchdog-abort strobes
  always_comb begin
    state_nx_s = state_r;
    grant_i_s  = 1'b0;
    grant_d_s  = 1'b0;
    ack_s      = 1'b0;
    abort_s    = 1'b0;
    rdata_s    = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        // On a tie the port that was not served last wins
        if (bus.i_req && bus.d_req) begin
          if (last_d_r) begin
            grant_i_s = 1'b1;
          end else begin
            grant_d_s = 1'b1;
          end
        end else if (bus.i_req) begin
          grant_i_s = 1'b1;
        end else if (bus.d_req) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = 1'b0;
        end
        if (grant_i_s) begin
          state_nx_s = IBUSY;
        end else if (grant_d_s) begin
          state_nx_s = DBUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      IBUSY, DBUSY: begin
        if (bus.m_ack) begin
          ack_s      = 1'b1;
          rdata_s    = bus.m_rdata;
          state_nx_s = DONE;
        end else if (cnt_r >= CNT_LAST) begin
          abort_s    = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = state_r;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Memory request, captured read data, ready pulses, watchdog counter and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d_r  <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      m_req_r   <= 1'b0;
      m_we_r    <= 1'b0;
      m_addr_r  <= {ADDR_W{1'b0}};
      m_wdata_r <= {DATA_W{1'b0}};
      i_ready_r <= 1'b0;
      i_rdata_r <= {DATA_W{1'b0}};
      d_ready_r <= 1'b0;
      d_rdata_r <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      i_ready_r <= 1'b0;
      d_ready_r <= 1'b0;
      if (grant_i_s) begin
        m_req_r   <= 1'b1;
        m_we_r    <= 1'b0;
        m_addr_r  <= bus.i_addr;
        m_wdata_r <= {DATA_W{1'b0}};
        last_d_r  <= 1'b0;
        cnt_r     <= {CNT_W{1'b0}};
      end else if (grant_d_s) begin
        m_req_r   <= 1'b1;
        m_we_r    <= bus.d_we;
        m_addr_r  <= bus.d_addr;
        m_wdata_r <= bus.d_wdata;
        last_d_r  <= 1'b1;
        cnt_r     <= {CNT_W{1'b0}};
      end else if (ack_s || abort_s) begin
        m_req_r <= 1'b0;
        if (state_r == IBUSY) begin
          i_ready_r <= 1'b1;
          i_rdata_r <= rdata_s;
        end else begin
          d_ready_r <= 1'b1;
          // Stores leave the load result untouched
          if (!m_we_r) begin
            d_rdata_r <= rdata_s;
          end
        end
        if (abort_s) begin
          err_r <= 1'b1;
        end
      end else if (((state_r == IBUSY) || (state_r == DBUSY)) && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.m_req     = m_req_r;
  assign bus.m_we      = m_we_r;
  assign bus.m_addr    = m_addr_r;
  assign bus.m_wdata   = m_wdata_r;
  assign bus.i_ready   = i_ready_r;
  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_ready   = d_ready_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.err       = err_r;
  assign bus.stall_if  = bus.i_req & ~i_ready_r;
  assign bus.stall_mem = bus.d_req & ~d_ready_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a wait-state memory responder
// (TIMEOUT=4 so a 3-wait access just completes and a silent memory aborts).
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wait_cycles = 0;
  logic        never_ack = 1'b0;
  logic        ack_force = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  int          wcnt;

  // Memory responder: acks after wait_cycles cycles of m_req
  always @(posedge clk or negedge reset) begin
    if (!reset) wcnt <= 0;
    else if (bus.m_req && !bus.m_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign bus.m_ack   = ack_force | (bus.m_req & ~never_ack & (wcnt == wait_cycles));
  assign bus.m_rdata = mem_rdata;

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.i_req = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.m_req, bus.m_we, bus.i_ready, bus.d_ready, bus.err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {bus.m_req, bus.m_we, bus.i_ready, bus.d_ready, bus.err});
    end
    n_tests++;
    if ({bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata});
    end
    n_tests++;
    if ({bus.stall_if, bus.stall_mem} !== 2'b10) begin
      n_fail++; $display("FAIL reset_stall: got %b want 10", {bus.stall_if, bus.stall_mem});
    end
    bus.i_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    wait_cycles = 0; mem_rdata = 32'h8C010004;
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    #1;
    n_tests++;
    if (bus.stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall0: got %b want 1", bus.stall_if); end
    @(negedge clk);
    n_tests++;
    if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.i_ready, bus.stall_if} !== {1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fetch_busy: got req=%b we=%b addr=%h wd=%h rdy=%b stall=%b want 1 0 40 0 0 1",
                         bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.i_ready, bus.stall_if);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.i_ready, bus.i_rdata, bus.m_req, bus.stall_if} !== {1'b1, 32'h8C010004, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL fetch_ready: got rdy=%b rdata=%h req=%b stall=%b want 1 8c010004 0 0",
                         bus.i_ready, bus.i_rdata, bus.m_req, bus.stall_if);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.i_ready, bus.i_rdata} !== {1'b0, 32'h8C010004}) begin
      n_fail++; $display("FAIL fetch_hold: got rdy=%b rdata=%h want 0 8c010004", bus.i_ready, bus.i_rdata);
    end
  endtask

  task automatic test_load();
    wait_cycles = 0; mem_rdata = 32'h12345678;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20;
    @(negedge clk);
    n_tests++;
    if ({bus.m_req, bus.m_we, bus.m_addr, bus.stall_mem} !== {1'b1, 1'b0, 32'h20, 1'b1}) begin
      n_fail++; $display("FAIL load_busy: got req=%b we=%b addr=%h stall=%b want 1 0 20 1", bus.m_req, bus.m_we, bus.m_addr, bus.stall_mem);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.d_ready, bus.d_rdata} !== {1'b1, 32'h12345678}) begin
      n_fail++; $display("FAIL load_ready: got rdy=%b rdata=%h want 1 12345678", bus.d_ready, bus.d_rdata);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_wait();
    wait_cycles = 3; mem_rdata = 32'hDEADDEAD;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hCAFEBABE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.d_ready} !== {1'b1, 1'b1, 32'h10, 32'hCAFEBABE, 1'b0}) begin
        n_fail++; $display("FAIL store_busy%0d: got req=%b we=%b addr=%h wd=%h rdy=%b want 1 1 10 cafebabe 0",
                           k, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.d_ready);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({bus.d_ready, bus.d_rdata, bus.m_req, bus.err} !== {1'b1, 32'h12345678, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL store_ready: got rdy=%b rdata=%h req=%b err=%b want 1 12345678 0 0",
                         bus.d_ready, bus.d_rdata, bus.m_req, bus.err);
    end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    wait_cycles = 0;
    @(negedge clk);
  endtask

  task automatic test_alternate();
    logic [3:0] order;
    int         nrdy;
    logic       prev_rdy;
    logic       bad;
    order = 4'b0; nrdy = 0; prev_rdy = 1'b0; bad = 1'b0;
    reset = 1'b0;
    wait_cycles = 0; mem_rdata = 32'h55AA55AA;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (bus.i_ready && bus.d_ready) bad = 1'b1;
      if ((bus.i_ready || bus.d_ready) && prev_rdy) bad = 1'b1;
      if (bus.i_ready || bus.d_ready) begin
        if (nrdy < 4) order[3 - nrdy] = bus.d_ready;
        nrdy++;
      end
      prev_rdy = bus.i_ready | bus.d_ready;
    end
    n_tests++;
    if (order !== 4'b1010) begin n_fail++; $display("FAIL alt_order: got %b want 1010 (1=data)", order); end
    n_tests++;
    if (nrdy != 4) begin n_fail++; $display("FAIL alt_count: got %0d want 4", nrdy); end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL alt_pulse: got overlap/back-to-back ready %b want 0", bad); end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold_through_ready();
    int   grants, readies, seen;
    logic prev;
    grants = 0; readies = 0; seen = 100; prev = bus.m_req;
    wait_cycles = 0; mem_rdata = 32'h0000AAAA;
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.m_req && !prev) grants++;
      prev = bus.m_req;
      if (bus.i_ready) begin readies++; seen = c; end
      if (c == seen + 1) bus.i_req = 1'b0;
    end
    bus.i_req = 1'b0;
    n_tests++;
    if (grants != 1) begin n_fail++; $display("FAIL hold_grants: got %0d want 1", grants); end
    n_tests++;
    if (readies != 1) begin n_fail++; $display("FAIL hold_readies: got %0d want 1", readies); end
  endtask

  task automatic test_ack_when_idle();
    logic seen;
    seen = 1'b0;
    ack_force = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = seen | bus.m_req | bus.i_ready | bus.d_ready;
    end
    ack_force = 1'b0;
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_ack: got activity %b want 0", seen); end
  endtask

  task automatic test_timeout();
    logic bad;
    bad = 1'b0;
    never_ack = 1'b1; mem_rdata = 32'h77777777;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if ({bus.m_req, bus.d_ready, bus.err} !== 3'b100) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got early abort %b want 0", bad); end
    @(negedge clk);
    n_tests++;
    if ({bus.m_req, bus.d_ready, bus.d_rdata, bus.err} !== {1'b0, 1'b1, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_abort: got req=%b rdy=%b rdata=%h err=%b want 0 1 0 1",
                         bus.m_req, bus.d_ready, bus.d_rdata, bus.err);
    end
    bus.d_req = 1'b0;
    never_ack = 1'b0;
    @(negedge clk);
    wait_cycles = 0; mem_rdata = 32'h13579BDF;
    bus.i_req = 1'b1; bus.i_addr = 32'h50;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.i_ready, bus.i_rdata, bus.err} !== {1'b1, 32'h13579BDF, 1'b1}) begin
      n_fail++; $display("FAIL timeout_sticky: got rdy=%b rdata=%h err=%b want 1 13579bdf 1", bus.i_ready, bus.i_rdata, bus.err);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    wait_cycles = 3; mem_rdata = 32'h99999999;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.m_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got m_req=%b want 1", bus.m_req); end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.m_req, bus.m_we, bus.i_ready, bus.d_ready, bus.err, bus.m_addr, bus.d_rdata, bus.i_rdata} !== {5'b0, 96'h0}) begin
      n_fail++; $display("FAIL rstmid_clear: got req=%b err=%b addr=%h drd=%h ird=%h want all 0",
                         bus.m_req, bus.err, bus.m_addr, bus.d_rdata, bus.i_rdata);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_cycles = 0; mem_rdata = 32'h0BADF00D;
    bus.i_req = 1'b1; bus.i_addr = 32'h48;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.i_ready, bus.i_rdata, bus.err} !== {1'b1, 32'h0BADF00D, 1'b0}) begin
      n_fail++; $display("FAIL rstmid_after: got rdy=%b rdata=%h err=%b want 1 0badf00d 0", bus.i_ready, bus.i_rdata, bus.err);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_load();
    test_store_wait();
    test_alternate();
    test_hold_through_ready();
    test_ack_when_idle();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
